// File: rtl/jtag_dtm.sv
// JTAG debug transport module: 1149.1 TAP with IDCODE/BYPASS/DTMCS/DMI data
// registers, a DMI-to-bus request engine with timeout, and halt/reset requests.
module jtag_dtm #(
    parameter int unsigned IR_WIDTH   = 5,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1A57_E5E5,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  trst_n,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  rsp_err,
    input  logic                  halted,
    output logic                  halt_req,
    output logic                  reset_req
);

    localparam int unsigned DMI_LEN = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int unsigned DR_MAX  = (DMI_LEN > 32) ? DMI_LEN : 32;
    localparam int unsigned TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [3:0] TAP_TLR   = 4'h0;
    localparam logic [3:0] TAP_RTI   = 4'h1;
    localparam logic [3:0] TAP_SELDR = 4'h2;
    localparam logic [3:0] TAP_CAPDR = 4'h3;
    localparam logic [3:0] TAP_SHDR  = 4'h4;
    localparam logic [3:0] TAP_EX1DR = 4'h5;
    localparam logic [3:0] TAP_PADR  = 4'h6;
    localparam logic [3:0] TAP_EX2DR = 4'h7;
    localparam logic [3:0] TAP_UPDR  = 4'h8;
    localparam logic [3:0] TAP_SELIR = 4'h9;
    localparam logic [3:0] TAP_CAPIR = 4'hA;
    localparam logic [3:0] TAP_SHIR  = 4'hB;
    localparam logic [3:0] TAP_EX1IR = 4'hC;
    localparam logic [3:0] TAP_PAIR  = 4'hD;
    localparam logic [3:0] TAP_EX2IR = 4'hE;
    localparam logic [3:0] TAP_UPIR  = 4'hF;

    localparam logic [1:0] BUS_IDLE = 2'd0;
    localparam logic [1:0] BUS_REQ  = 2'd1;
    localparam logic [1:0] BUS_WAIT = 2'd2;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

    logic [3:0]            tap_q, tap_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
    logic [DR_MAX-1:0]     dr_q, dr_d;
    logic                  halt_q, halt_d;
    logic                  rst_req_q, rst_req_d;
    logic [1:0]            sticky_q, sticky_d;
    logic [1:0]            bus_q, bus_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] last_rdata_q, last_rdata_d;

    logic                  sel_idcode, sel_dtmcs, sel_dmi;
    int unsigned           dr_len;
    logic                  busy;
    logic [1:0]            dmi_status;
    logic [31:0]           dtmcs_cap;
    logic [DMI_LEN-1:0]    dmi_cap;
    logic [DR_MAX-1:0]     dr_shr;
    logic [1:0]            dmi_op;
    logic [DATA_WIDTH-1:0] dmi_data;
    logic [ADDR_WIDTH-1:0] dmi_addr;
    logic                  upd_dtmcs, upd_dmi_rw, bus_err;

    always_comb begin
        sel_idcode = (ir_q == IR_IDCODE);
        sel_dtmcs  = (ir_q == IR_DTMCS);
        sel_dmi    = (ir_q == IR_DMI);
        if (sel_idcode || sel_dtmcs) dr_len = 32;
        else if (sel_dmi)            dr_len = DMI_LEN;
        else                         dr_len = 1;
    end

    always_comb begin
        busy       = (bus_q != BUS_IDLE);
        dmi_status = (sticky_q != 2'd0) ? sticky_q : (busy ? 2'd3 : 2'd0);
        dtmcs_cap        = '0;
        dtmcs_cap[21]    = rst_req_q;
        dtmcs_cap[20]    = halt_q;
        dtmcs_cap[17]    = halted;
        dtmcs_cap[16]    = busy;
        dtmcs_cap[11:10] = sticky_q;
        dtmcs_cap[9:4]   = 6'(ADDR_WIDTH);
        dtmcs_cap[3:0]   = 4'd1;
        dmi_cap    = {last_addr_q, last_rdata_q, dmi_status};
        dr_shr     = {1'b0, dr_q[DR_MAX-1:1]};
        dmi_op     = dr_q[1:0];
        dmi_data   = dr_q[DATA_WIDTH+1:2];
        dmi_addr   = dr_q[DMI_LEN-1:DATA_WIDTH+2];
        upd_dtmcs  = (tap_q == TAP_UPDR) && sel_dtmcs;
        upd_dmi_rw = (tap_q == TAP_UPDR) && sel_dmi && (dmi_op == 2'd1 || dmi_op == 2'd2);
    end

    // TAP state graph
    always_comb begin
        tap_d = tap_q;
        case (tap_q)
            TAP_TLR:   tap_d = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   tap_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: tap_d = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: tap_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  tap_d = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: tap_d = tms ? TAP_UPDR  : TAP_PADR;
            TAP_PADR:  tap_d = tms ? TAP_EX2DR : TAP_PADR;
            TAP_EX2DR: tap_d = tms ? TAP_UPDR  : TAP_SHDR;
            TAP_UPDR:  tap_d = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: tap_d = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: tap_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  tap_d = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: tap_d = tms ? TAP_UPIR  : TAP_PAIR;
            TAP_PAIR:  tap_d = tms ? TAP_EX2IR : TAP_PAIR;
            TAP_EX2IR: tap_d = tms ? TAP_UPIR  : TAP_SHIR;
            TAP_UPIR:  tap_d = tms ? TAP_SELDR : TAP_RTI;
            default:   tap_d = TAP_TLR;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        dr_d       = dr_q;
        case (tap_q)
            TAP_TLR:   ir_d = IR_IDCODE;
            TAP_CAPIR: ir_shift_d = IR_WIDTH'(1);
            TAP_SHIR:  ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            TAP_UPIR:  ir_d = ir_shift_q;
            TAP_CAPDR: begin
                dr_d = '0;
                if (sel_idcode)     dr_d[31:0] = IDCODE_VAL;
                else if (sel_dtmcs) dr_d[31:0] = dtmcs_cap;
                else if (sel_dmi)   dr_d[DMI_LEN-1:0] = dmi_cap;
            end
            TAP_SHDR: begin
                // tdi enters at the top of the currently selected register length
                for (int unsigned i = 0; i < DR_MAX; i++) begin
                    if (i == dr_len - 1)     dr_d[i] = tdi;
                    else if (i < dr_len - 1) dr_d[i] = dr_shr[i];
                    else                     dr_d[i] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus_d        = bus_q;
        tmo_d        = tmo_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_addr_d  = last_addr_q;
        last_rdata_d = last_rdata_q;
        bus_err      = 1'b0;
        case (bus_q)
            BUS_IDLE: begin
                if (upd_dmi_rw && sticky_q == 2'd0) begin
                    bus_d       = BUS_REQ;
                    tmo_d       = '0;
                    write_d     = (dmi_op == 2'd2);
                    addr_d      = dmi_addr;
                    wdata_d     = dmi_data;
                    last_addr_d = dmi_addr;
                end
            end
            BUS_REQ: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == TMO_LAST) begin
                    bus_d   = BUS_IDLE;
                    bus_err = 1'b1;
                end else if (req_ready) begin
                    bus_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // a response arriving on the final cycle beats the timeout
                if (rsp_valid) begin
                    if (!write_q) last_rdata_d = rsp_rdata;
                    bus_err = rsp_err;
                    bus_d   = BUS_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    bus_d   = BUS_IDLE;
                    bus_err = 1'b1;
                end
            end
            default: bus_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        sticky_d  = sticky_q;
        halt_d    = halt_q;
        rst_req_d = rst_req_q;
        if (upd_dtmcs) begin
            if (dr_q[16]) sticky_d = 2'd0;
            halt_d    = dr_q[20];
            rst_req_d = dr_q[21];
        end
        // busy-overrun only marks a clean status; a bus error always wins
        if (upd_dmi_rw && busy && sticky_d == 2'd0) sticky_d = 2'd3;
        if (bus_err) sticky_d = 2'd2;
        if (tap_q == TAP_TLR) begin
            sticky_d  = 2'd0;
            halt_d    = 1'b0;
            rst_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge trst_n) begin
        if (!trst_n) begin
            tap_q        <= TAP_TLR;
            ir_q         <= IR_IDCODE;
            ir_shift_q   <= '0;
            dr_q         <= '0;
            halt_q       <= 1'b0;
            rst_req_q    <= 1'b0;
            sticky_q     <= '0;
            bus_q        <= BUS_IDLE;
            tmo_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_addr_q  <= '0;
            last_rdata_q <= '0;
        end else begin
            tap_q        <= tap_d;
            ir_q         <= ir_d;
            ir_shift_q   <= ir_shift_d;
            dr_q         <= dr_d;
            halt_q       <= halt_d;
            rst_req_q    <= rst_req_d;
            sticky_q     <= sticky_d;
            bus_q        <= bus_d;
            tmo_q        <= tmo_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_addr_q  <= last_addr_d;
            last_rdata_q <= last_rdata_d;
        end
    end

    always_comb begin
        tdo_en    = (tap_q == TAP_SHIR) || (tap_q == TAP_SHDR);
        tdo       = (tap_q == TAP_SHIR) ? ir_shift_q[0] :
                    (tap_q == TAP_SHDR) ? dr_q[0] : 1'b0;
        req_valid = (bus_q == BUS_REQ);
        req_write = write_q;
        req_addr  = addr_q;
        req_wdata = wdata_q;
        halt_req  = halt_q;
        reset_req = rst_req_q;
    end

endmodule
